reg_write_arbiter: RTL and testbench

Write-port arbiter for the CPU's bank of ten-bit registers. Up to four datapath requesters (fetch, ALU writeback, memory load, control) compete for one shared write path. The block grants one requester per cycle in round-robin order and drives the `d`/`w` inputs of the selected register. All outputs are registered, so the bank sees clean one-cycle write strobes aligned to `clk`.

---
 rtl/reg_write_arbiter_pkg.sv | 15 +
 rtl/reg_write_arbiter_rr_pick.sv | 33 +++
 rtl/reg_write_arbiter.sv | 123 ++++++++++++
 tb/tb_reg_write_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_write_arbiter_pkg.sv
// reg_arb_pkg: shared defaults for the register write-port arbiter.
//   DEF_NUM_REQ / DEF_DATA_W / DEF_NUM_REGS / DEF_ADDR_W : default widths
//   ptr_w() : width of the round-robin pointer for a given requester count
package reg_arb_pkg;

  localparam int unsigned DEF_NUM_REQ  = 4;
  localparam int unsigned DEF_DATA_W   = 10;
  localparam int unsigned DEF_NUM_REGS = 8;
  localparam int unsigned DEF_ADDR_W   = 3;

  function automatic int unsigned ptr_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   elig  : eligible requester vector
//   ptr   : index where the search starts (wraps N-1 -> 0)
//   win   : one-hot winner
//   valid : a winner exists
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int unsigned N  = DEF_NUM_REQ,
  parameter int unsigned PW = ptr_w(DEF_NUM_REQ)
) (
  input  logic [N-1:0]  elig,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic          valid
);

  int unsigned idx;

  always_comb begin
    win   = '0;
    valid = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr) + k) % N;
      if (!valid && elig[idx]) begin
        win[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter for the shared register write path.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   req        : per-requester level write request
//   req_addr   : packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data   : packed data, requester i at [i*DATA_W +: DATA_W]
//   lock       : (REG_ARB_LOCK_EN only) keep the grant on the current winner
//   gnt        : registered one-hot grant
//   wr_en      : registered one-hot register write enable
//   wr_data    : registered shared write data (holds when idle)
//   addr_err   : granted address was >= NUM_REGS
//   busy       : some output strobe is active this cycle
// Optional feature macro: REG_ARB_LOCK_EN.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ADDR_W   = DEF_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
`ifdef REG_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        lock,
`endif
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REGS-1:0]       wr_en,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      addr_err,
  output logic                      busy
);

  localparam int unsigned PW = ptr_w(NUM_REQ);

  logic [PW-1:0]      ptr;
  logic [PW-1:0]      ptr_next;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] rr_win;
  logic               rr_valid;
  logic [NUM_REQ-1:0] sel;
  logic               sel_valid;
  logic               locked;
  logic [PW-1:0]      sel_idx;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               addr_ok;
  logic [NUM_REGS-1:0] en_next;

  // A requester granted this cycle is masked so its still-high req is not
  // written twice. The registered gnt doubles as the lock state: a lock only
  // ever extends the requester currently holding the grant.
  assign elig = req & ~gnt;

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .elig  (elig),
    .ptr   (ptr),
    .win   (rr_win),
    .valid (rr_valid)
  );

`ifdef REG_ARB_LOCK_EN
  logic [NUM_REQ-1:0] lock_hit;
  assign lock_hit = gnt & lock & req;
  assign locked   = |lock_hit;
  assign sel      = locked ? lock_hit : rr_win;
`else
  assign locked   = 1'b0;
  assign sel      = rr_win;
`endif
  assign sel_valid = locked | rr_valid;

  always_comb begin
    sel_idx  = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (sel[i]) begin
        sel_idx  = PW'(i);
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign ptr_next = (32'(sel_idx) == NUM_REQ - 1) ? '0 : sel_idx + 1'b1;
  assign addr_ok  = (32'(sel_addr) < NUM_REGS);

  always_comb begin
    en_next = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      en_next[r] = sel_valid && addr_ok && (32'(sel_addr) == r);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt      <= '0;
      wr_en    <= '0;
      wr_data  <= '0;
      addr_err <= 1'b0;
      busy     <= 1'b0;
      ptr      <= '0;
    end else begin
      gnt      <= sel;
      wr_en    <= en_next;
      addr_err <= sel_valid & ~addr_ok;
      busy     <= sel_valid;
      if (sel_valid) begin
        wr_data <= sel_data;
      end
      if (sel_valid && !locked) begin
        ptr <= ptr_next;
      end
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter (4 requesters, 6-register bank).
module tb_reg_write_arbiter;

  localparam int unsigned NQ = 4;
  localparam int unsigned DW = 10;
  localparam int unsigned NR = 6;
  localparam int unsigned AW = 3;

  logic           clk;
  logic           rst_n;
  logic [NQ-1:0]  req;
  logic [AW-1:0]  a [NQ];
  logic [DW-1:0]  d [NQ];
  logic [NQ*AW-1:0] req_addr;
  logic [NQ*DW-1:0] req_data;
`ifdef REG_ARB_LOCK_EN
  logic [NQ-1:0]  lock;
`endif
  logic [NQ-1:0]  gnt;
  logic [NR-1:0]  wr_en;
  logic [DW-1:0]  wr_data;
  logic           addr_err;
  logic           busy;
  logic [DW-1:0]  bank [NR];

  int n_cmp;
  int n_err;

  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < NQ; i++) begin
      req_addr[i*AW +: AW] = a[i];
      req_data[i*DW +: DW] = d[i];
    end
  end

  // Register bank the arbiter drives.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NR; r++) begin
      if (wr_en[r]) bank[r] <= wr_data;
    end
  end

  reg_write_arbiter #(
    .NUM_REQ  (NQ),
    .DATA_W   (DW),
    .NUM_REGS (NR),
    .ADDR_W   (AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
`ifdef REG_ARB_LOCK_EN
    .lock     (lock),
`endif
    .gnt      (gnt),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .addr_err (addr_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".gnt"}, 32'(gnt), 32'h0);
    chk({tag, ".wr_en"}, 32'(wr_en), 32'h0);
    chk({tag, ".addr_err"}, 32'(addr_err), 32'h0);
    chk({tag, ".busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    req   = '0;
`ifdef REG_ARB_LOCK_EN
    lock  = '0;
`endif
    for (int i = 0; i < NQ; i++) begin
      a[i] = '0;
      d[i] = '0;
    end

    // Reset state
    #7;
    chk_idle("rst");
    chk("rst.wr_data", 32'(wr_data), 32'h0);
    #15;
    rst_n = 1'b1;

    // Contention: all four request, addrs 0..3, data 1..4; ptr starts at 0
    for (int i = 0; i < NQ; i++) begin
      a[i] = AW'(i);
      d[i] = DW'(i + 1);
    end
    req = 4'b1111;
    for (int k = 0; k < NQ; k++) begin
      tick();
      chk($sformatf("cont%0d.gnt", k), 32'(gnt), 32'(1) << k);
      chk($sformatf("cont%0d.wr_en", k), 32'(wr_en), 32'(1) << k);
      chk($sformatf("cont%0d.wr_data", k), 32'(wr_data), 32'(k + 1));
      req[k] = 1'b0;
    end
    tick();
    chk_idle("cont.end");
    chk("cont.hold", 32'(wr_data), 32'd4);
    for (int r = 0; r < 4; r++) begin
      chk($sformatf("cont.bank%0d", r), 32'(bank[r]), 32'(r + 1));
    end

    // Single write: ptr back at 0, req0 addr 2 data 45
    a[0] = 3'd2;
    d[0] = 10'd45;
    req  = 4'b0001;
    tick();
    chk("single.gnt", 32'(gnt), 32'h1);
    chk("single.wr_en", 32'(wr_en), 32'h4);
    chk("single.wr_data", 32'(wr_data), 32'd45);
    chk("single.busy", 32'(busy), 32'h1);
    chk("single.addr_err", 32'(addr_err), 32'h0);
    req = '0;
    tick();
    chk_idle("single.after");
    chk("single.bank2", 32'(bank[2]), 32'd45);

    // Invalid address: req1 addr 7 with a 6-register bank
    a[1] = 3'd7;
    d[1] = 10'd99;
    req  = 4'b0010;
    tick();
    chk("inv.gnt", 32'(gnt), 32'h2);
    chk("inv.addr_err", 32'(addr_err), 32'h1);
    chk("inv.wr_en", 32'(wr_en), 32'h0);
    chk("inv.wr_data", 32'(wr_data), 32'd99);
    chk("inv.busy", 32'(busy), 32'h1);
    req = '0;
    tick();
    chk_idle("inv.after");
    chk("inv.bank2", 32'(bank[2]), 32'd45);

    // Masking: req2 held alone -> grant on alternate cycles
    a[2] = 3'd1;
    d[2] = 10'd7;
    req  = 4'b0100;
    tick();
    chk("mask0.gnt", 32'(gnt), 32'h4);
    tick();
    chk("mask1.gnt", 32'(gnt), 32'h0);
    chk("mask1.busy", 32'(busy), 32'h0);
    tick();
    chk("mask2.gnt", 32'(gnt), 32'h4);
    chk("mask2.wr_en", 32'(wr_en), 32'h2);

    // Mid-grant reset: ptr is 3 here, reset must return it to 0
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("mrst");
    chk("mrst.wr_data", 32'(wr_data), 32'h0);
    a[1] = 3'd5;
    d[1] = 10'd11;
    a[3] = 3'd4;
    d[3] = 10'd22;
    req  = 4'b1010;
    tick();
    chk("mrst.held.gnt", 32'(gnt), 32'h0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("rel.gnt", 32'(gnt), 32'h2);
    chk("rel.wr_en", 32'(wr_en), 32'h20);
    chk("rel.wr_data", 32'(wr_data), 32'd11);
    req = 4'b1000;
    tick();
    chk("rel2.gnt", 32'(gnt), 32'h8);
    chk("rel2.wr_en", 32'(wr_en), 32'h10);
    chk("rel2.wr_data", 32'(wr_data), 32'd22);
    req = '0;
    tick();
    chk_idle("rel.end");
    chk("rel.bank5", 32'(bank[5]), 32'd11);
    chk("rel.bank4", 32'(bank[4]), 32'd22);

`ifdef REG_ARB_LOCK_EN
    // Lock: req2 with lock2 held is granted every cycle
    req  = 4'b0100;
    lock = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("lock%0d.gnt", k), 32'(gnt), 32'h4);
    end
    lock = '0;
    tick();
    chk("lock.rel.gnt", 32'(gnt), 32'h0);
    req = '0;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
